turn_signal_seq: RTL

Parametrised successor to the team's Thunderbird tail-light FSM. Drives LAMPS lamps per side through left, right and hazard flash sequences. Adds an internal flash-rate prescaler and a brake overlay. Sits between the steering-column switch decode and the lamp drivers.

---
 rtl/turn_signal_seq.sv | 94 +++++++++
 1 files changed

// File: rtl/turn_signal_seq.sv
// Left/right/hazard lamp sequencer with flash-rate prescaler and brake overlay.
// lamps updates on the tick edge for sequence changes, one edge after sampling for brake; en=0 freezes all state.
module turn_signal_seq #(
   parameter int LAMPS    = 3,
   parameter int TICK_DIV = 1
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               en,
   input  logic               left,
   input  logic               right,
   input  logic               haz,
   input  logic               brake,
   output logic [2*LAMPS-1:0] lamps
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(LAMPS + 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LEFT  = 2'd1,
      S_RIGHT = 2'd2,
      S_HAZ   = 2'd3
   } mode_t;

   logic [CW-1:0]    cnt;
   mode_t            mode;
   logic [SW-1:0]    step;

   logic             tick;
   mode_t            req;
   mode_t            nxt_mode;
   logic [SW-1:0]    nxt_step;
   logic [LAMPS-1:0] lbank;
   logic [LAMPS-1:0] rbank;

   always_comb begin
      tick = en && (cnt == CW'(TICK_DIV - 1));

      if (haz || (left && right)) req = S_HAZ;
      else if (left)              req = S_LEFT;
      else if (right)             req = S_RIGHT;
      else                        req = S_IDLE;

      nxt_mode = mode;
      nxt_step = step;
      if (tick) begin
         if (req != mode) begin
            // every mode change starts with one all-off step
            nxt_mode = req;
            nxt_step = '0;
         end else begin
            case (mode)
               S_LEFT, S_RIGHT: nxt_step = (step == SW'(LAMPS)) ? '0 : step + 1'b1;
               S_HAZ:           nxt_step = (step == '0) ? SW'(1) : '0;
               default:         nxt_step = '0;
            endcase
         end
      end

      lbank = '0;
      rbank = '0;
      for (int i = 0; i < LAMPS; i++) begin
         if (SW'(i) < nxt_step) begin
            if (nxt_mode == S_LEFT)  lbank[i] = 1'b1;
            if (nxt_mode == S_RIGHT) rbank[LAMPS-1-i] = 1'b1;
         end
      end
      if (nxt_mode == S_HAZ) begin
         lbank = {LAMPS{nxt_step[0]}};
         rbank = {LAMPS{nxt_step[0]}};
      end else if (brake) begin
         // brake lights every bank that is not currently sequencing
         if (nxt_mode != S_LEFT)  lbank = '1;
         if (nxt_mode != S_RIGHT) rbank = '1;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt   <= '0;
         mode  <= S_IDLE;
         step  <= '0;
         lamps <= '0;
      end else if (en) begin
         cnt   <= tick ? '0 : cnt + 1'b1;
         mode  <= nxt_mode;
         step  <= nxt_step;
         lamps <= {lbank, rbank};
      end
   end

endmodule
